// File: rtl/priority_encoder_32.sv
// Sequential 32-to-5 priority encoder: captures a request vector and hands out
// the index of each set bit, lowest first, one per valid/ready handshake.
module priority_encoder_32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SEL_W-1:0] select,
  output logic [WIDTH-1:0] pending,
  output logic [SEL_W:0]   served_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic take;
  logic accept;
  logic last;

  always_comb begin
    take   = enable & load & (state_q == IDLE);
    accept = enable & out_ready & (state_q == SCAN);
    // Exactly one bit left when clearing the lowest set bit leaves zero.
    last   = ((pending & (pending - WIDTH'(1))) == '0);
  end

  // Lowest-indexed set bit wins; scanning downward lets the lowest overwrite.
  always_comb begin
    select = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (pending[i-1]) begin
        select = SEL_W'(i - 1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take && (req_in != '0)) state_d = SCAN;
      SCAN: if (accept && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == SCAN);
    busy      = (state_q == SCAN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      served_count <= '0;
      done         <= 1'b0;
    end else begin
      done <= (take && (req_in == '0)) || (accept && last);
      if (take) begin
        pending      <= req_in;
        served_count <= '0;
      end else if (accept) begin
        pending      <= pending & ~(WIDTH'(1) << select);
        served_count <= served_count + 1'b1;
      end
    end
  end

endmodule
